// File: rtl/drum_grid_engine.sv
// Time-multiplexed damped 2-D wave engine: ROWS x COLS node grid held in two
// register banks, one node updated per clock, tap node published per step.
module drum_grid_engine #(
  parameter int ROWS       = 8,
  parameter int COLS       = 8,
  parameter int DW         = 18,
  parameter int DAMP_SHIFT = 9
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_load_start,
  input  logic                     i_init_valid,
  output logic                     o_init_ready,
  input  logic [DW-1:0]            i_init_data,
  input  logic                     i_step_start,
  input  logic [DW-1:0]            i_rho,
  input  logic [$clog2(ROWS)-1:0]  i_tap_row,
  input  logic [$clog2(COLS)-1:0]  i_tap_col,
  output logic                     o_busy,
  output logic                     o_step_done,
  output logic [DW-1:0]            o_tap_out,
  output logic [15:0]              o_step_count
);

  localparam int N  = ROWS * COLS;
  localparam int AW = $clog2(N);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int PW = 2 * DW + 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic signed [PW-1:0] SMAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [PW-1:0] SMIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic [1:0]              r_state;
  logic [AW-1:0]           r_idx;
  logic [RW-1:0]           r_row;
  logic [CW-1:0]           r_col;
  logic                    r_sel;
  logic signed [DW-1:0]    r_rho;
  logic [RW-1:0]           r_tap_row;
  logic [CW-1:0]           r_tap_col;
  logic [DW-1:0]           r_tap_out;
  logic [15:0]             r_step_count;
  logic signed [DW-1:0]    r_bank0 [N];
  logic signed [DW-1:0]    r_bank1 [N];

  logic                    w_last;
  logic [AW-1:0]           w_il, w_ir, w_iu, w_id;
  logic signed [DW-1:0]    w_uc, w_ul, w_ur, w_uu, w_ud, w_up;
  logic signed [DW+2:0]    w_lap;
  logic signed [PW-1:0]    w_prod, w_p, w_n, w_d;
  logic signed [DW-1:0]    w_sat;
  logic                    w_tap_ok;
  logic [AW-1:0]           w_tap_idx;
  logic [DW-1:0]           w_tap_val;

  function automatic logic signed [DW+2:0] ext3(input logic signed [DW-1:0] v);
    return {{3{v[DW-1]}}, v};
  endfunction

  function automatic logic signed [PW-1:0] extp(input logic signed [DW-1:0] v);
    return {{(PW-DW){v[DW-1]}}, v};
  endfunction

  assign w_last = (r_idx == AW'(N-1));
  assign w_il   = r_idx - AW'(1);
  assign w_ir   = r_idx + AW'(1);
  assign w_iu   = r_idx - AW'(COLS);
  assign w_id   = r_idx + AW'(COLS);

  // Neighbours come from the current bank; off-grid neighbours read as zero.
  always_comb begin
    w_uc = r_sel ? r_bank1[r_idx] : r_bank0[r_idx];
    w_up = r_sel ? r_bank0[r_idx] : r_bank1[r_idx];
    w_ul = '0;
    w_ur = '0;
    w_uu = '0;
    w_ud = '0;
    if (r_col != '0)             w_ul = r_sel ? r_bank1[w_il] : r_bank0[w_il];
    if (r_col != CW'(COLS-1))    w_ur = r_sel ? r_bank1[w_ir] : r_bank0[w_ir];
    if (r_row != '0)             w_uu = r_sel ? r_bank1[w_iu] : r_bank0[w_iu];
    if (r_row != RW'(ROWS-1))    w_ud = r_sel ? r_bank1[w_id] : r_bank0[w_id];
  end

  assign w_lap  = ext3(w_ul) + ext3(w_ur) + ext3(w_uu) + ext3(w_ud) - (ext3(w_uc) <<< 2);
  assign w_prod = $signed({{(PW-DW){r_rho[DW-1]}}, r_rho}) *
                  $signed({{(PW-DW-3){w_lap[DW+2]}}, w_lap});
  assign w_p    = w_prod >>> (DW-1);
  assign w_n    = w_p + (extp(w_uc) <<< 1) - extp(w_up);
  assign w_d    = w_n - (w_n >>> DAMP_SHIFT);
  assign w_sat  = (w_d > SMAX) ? SMAX[DW-1:0] :
                  (w_d < SMIN) ? SMIN[DW-1:0] : w_d[DW-1:0];

  assign w_tap_ok  = (32'(r_tap_row) < ROWS) && (32'(r_tap_col) < COLS);
  assign w_tap_idx = AW'(32'(r_tap_row) * COLS + 32'(r_tap_col));

  // The tap node may be the one being written on the final RUN edge, so bypass it.
  always_comb begin
    w_tap_val = r_sel ? r_bank0[w_tap_idx] : r_bank1[w_tap_idx];
    if (w_tap_idx == r_idx) w_tap_val = w_sat;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_sel        <= 1'b0;
      r_rho        <= '0;
      r_tap_row    <= '0;
      r_tap_col    <= '0;
      r_tap_out    <= '0;
      r_step_count <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        r_bank0[i] <= '0;
        r_bank1[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_idx <= '0;
          r_row <= '0;
          r_col <= '0;
          if (i_load_start) begin
            r_state <= S_LOAD;
          end else if (i_step_start) begin
            r_state   <= S_RUN;
            r_rho     <= i_rho;
            r_tap_row <= i_tap_row;
            r_tap_col <= i_tap_col;
          end
        end
        S_LOAD: begin
          if (i_init_valid) begin
            r_bank0[r_idx] <= i_init_data;
            r_bank1[r_idx] <= i_init_data;
            r_idx          <= r_idx + AW'(1);
            if (w_last) begin
              r_state      <= S_IDLE;
              r_step_count <= '0;
            end
          end
        end
        S_RUN: begin
          if (r_sel) r_bank0[r_idx] <= w_sat;
          else       r_bank1[r_idx] <= w_sat;
          r_idx <= r_idx + AW'(1);
          if (r_col == CW'(COLS-1)) begin
            r_col <= '0;
            r_row <= r_row + RW'(1);
          end else begin
            r_col <= r_col + CW'(1);
          end
          if (w_last) begin
            r_state      <= S_DONE;
            r_sel        <= ~r_sel;
            r_step_count <= r_step_count + 16'd1;
            if (w_tap_ok) r_tap_out <= w_tap_val;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_init_ready = (r_state == S_LOAD);
  assign o_busy       = (r_state != S_IDLE);
  assign o_step_done  = (r_state == S_DONE);
  assign o_tap_out    = r_tap_out;
  assign o_step_count = r_step_count;

endmodule

// File: tb/tb_drum_grid_engine.sv
// Scoreboard bench for drum_grid_engine: directed loads/steps, monitor checks
// tap_out, step_count and latency on every step_done pulse.
module tb_drum_grid_engine;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int DW   = 18;
  localparam int N    = ROWS * COLS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          init_valid = 1'b0;
  logic          step_start = 1'b0;
  logic          init_ready, busy, step_done;
  logic [DW-1:0] init_data = '0;
  logic [DW-1:0] rho = '0;
  logic [DW-1:0] tap_out;
  logic [2:0]    tap_row = '0;
  logic [2:0]    tap_col = '0;
  logic [15:0]   step_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [DW-1:0] tap;
    logic [15:0]   cnt;
    int            when;
  } exp_t;
  exp_t q[$];

  logic [DW-1:0] grid [N];

  drum_grid_engine #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .DAMP_SHIFT(9)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_load_start (load_start),
    .i_init_valid (init_valid),
    .o_init_ready (init_ready),
    .i_init_data  (init_data),
    .i_step_start (step_start),
    .i_rho        (rho),
    .i_tap_row    (tap_row),
    .i_tap_col    (tap_col),
    .o_busy       (busy),
    .o_step_done  (step_done),
    .o_tap_out    (tap_out),
    .o_step_count (step_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && step_done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_step_done: got pulse at cycle %0d required none", cyc);
      end else begin
        e = q.pop_front();
        chk("tap_out", 32'(tap_out), 32'(e.tap));
        chk("step_count", 32'(step_count), 32'(e.cnt));
        chk("done_latency", 32'(cyc), 32'(e.when));
      end
    end
  end

  task automatic set_impulse(input int r, input int c);
    for (int i = 0; i < N; i++) grid[i] = '0;
    grid[r*COLS+c] = 18'h10000;
  endtask

  task automatic load_grid(input bit gaps, input bit poke, input bit both);
    int i = 0;
    int g = 0;
    @(negedge clk); load_start = 1'b1; step_start = both;
    @(negedge clk); load_start = 1'b0; step_start = 1'b0;
    while (i < N && g < 1000) begin
      if (gaps && (g % 4 == 3)) begin
        init_valid = 1'b0;
      end else begin
        init_valid = 1'b1;
        init_data  = grid[i];
        if (init_ready) i++;
      end
      step_start = poke && (g == 10);
      load_start = poke && (g == 20);
      g++;
      @(negedge clk);
    end
    init_valid = 1'b0; step_start = 1'b0; load_start = 1'b0;
    if (i < N) begin
      checks++; errors++;
      $display("FAIL load_timeout: got %0d words accepted required %0d", i, N);
    end
    chk("init_ready_drop", 32'(init_ready), 32'd0);
    chk("busy_after_load", 32'(busy), 32'd0);
    chk("count_after_load", 32'(step_count), 32'd0);
  endtask

  task automatic do_step(input logic [DW-1:0] r, input int tr, input int tc,
                         input logic [DW-1:0] etap, input logic [15:0] ecnt, input bit poke);
    exp_t e;
    int g = 0;
    @(negedge clk);
    step_start = 1'b1; rho = r; tap_row = 3'(tr); tap_col = 3'(tc);
    e.tap = etap; e.cnt = ecnt; e.when = cyc + 65;
    q.push_back(e);
    @(negedge clk); step_start = 1'b0;
    if (poke) begin
      repeat (10) @(negedge clk);
      chk("busy_in_run", 32'(busy), 32'd1);
      step_start = 1'b1; load_start = 1'b1; rho = 18'h3FFFF; tap_row = '0; tap_col = '0;
      @(negedge clk); step_start = 1'b0; load_start = 1'b0;
    end
    while (!step_done && g < 200) begin
      @(negedge clk); g++;
    end
    if (!step_done) begin
      checks++; errors++;
      $display("FAIL step_timeout: got no step_done in %0d cycles required one", g);
    end
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tap_out", 32'(tap_out), 32'd0);
    chk("rst_step_count", 32'(step_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_init_ready", 32'(init_ready), 32'd0);
    chk("rst_step_done", 32'(step_done), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) grid[i] = '0;
    load_grid(1'b1, 1'b1, 1'b0);
    do_step(18'h08000, 3, 3, 18'h00000, 16'd1, 1'b0);
    do_step(18'h08000, 3, 3, 18'h00000, 16'd2, 1'b1);
    do_step(18'h08000, 3, 3, 18'h00000, 16'd3, 1'b0);

    set_impulse(3, 3);
    load_grid(1'b0, 1'b0, 1'b0);
    do_step(18'h00000, 3, 3, 18'h0FF80, 16'd1, 1'b0);
    load_grid(1'b0, 1'b0, 1'b0);
    do_step(18'h08000, 3, 4, 18'h03FE0, 16'd1, 1'b1);
    load_grid(1'b0, 1'b0, 1'b0);
    do_step(18'h08000, 3, 3, 18'h00000, 16'd1, 1'b0);

    set_impulse(0, 0);
    load_grid(1'b0, 1'b0, 1'b0);
    do_step(18'h08000, 0, 1, 18'h03FE0, 16'd1, 1'b0);
    load_grid(1'b0, 1'b0, 1'b0);
    do_step(18'h08000, 0, 7, 18'h00000, 16'd1, 1'b0);
    load_grid(1'b0, 1'b0, 1'b0);
    do_step(18'h08000, 7, 0, 18'h00000, 16'd1, 1'b0);

    set_impulse(3, 3);
    load_grid(1'b1, 1'b0, 1'b1);
    repeat (80) @(negedge clk);
    chk("count_after_load_step", 32'(step_count), 32'd0);
    do_step(18'h08000, 3, 4, 18'h03FE0, 16'd1, 1'b0);

    @(negedge clk);
    step_start = 1'b1; rho = 18'h08000; tap_row = 3'd3; tap_col = 3'd4;
    @(negedge clk); step_start = 1'b0;
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_tap_out", 32'(tap_out), 32'd0);
    chk("midrun_step_count", 32'(step_count), 32'd0);
    chk("midrun_busy", 32'(busy), 32'd0);
    chk("midrun_step_done", 32'(step_done), 32'd0);
    chk("midrun_init_ready", 32'(init_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    do_step(18'h08000, 3, 4, 18'h00000, 16'd1, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
